// File: rtl/road_game_sequencer.sv
// Game-flow controller for the scrolling-road game: phases, lives, BCD score, level.
// Optional HISCORE_EN adds a BCD high-score register and hiscore output.
module road_game_sequencer #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned COUNT_FRAMES = 60,
  parameter int unsigned LEVEL_FRAMES = 600,
  parameter int unsigned MAX_LEVEL    = 8,
  parameter int unsigned CRASH_FRAMES = 90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        frame_tick,
  input  logic        crash,
  output logic        road_run,
  output logic        road_clear,
  output logic [3:0]  level,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic [1:0]  count_digit,
  output logic [2:0]  game_state
`ifdef HISCORE_EN
  ,
  output logic [15:0] hiscore
`endif
);

  localparam int unsigned FMAX = (COUNT_FRAMES > CRASH_FRAMES) ? COUNT_FRAMES : CRASH_FRAMES;
  localparam int unsigned FW   = $clog2(FMAX + 1);
  localparam int unsigned LW   = $clog2(LEVEL_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSE     = 3'd3,
    S_CRASH     = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic          start_q, pause_q;
  logic          start_rise, pause_rise;
  logic [FW-1:0] frame_cnt, frame_cnt_nxt;
  logic [LW-1:0] level_cnt, level_cnt_nxt;
  logic [3:0]    level_nxt;
  logic [1:0]    lives_nxt;
  logic [15:0]   score_nxt;
  logic [1:0]    digit_nxt;
  logic          road_run_nxt, road_clear_nxt;
`ifdef HISCORE_EN
  logic [15:0]   hiscore_nxt;
`endif

  // Per-digit BCD increment, saturating at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = '0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign start_rise = start_btn & ~start_q;
  assign pause_rise = pause_btn & ~pause_q;
  assign game_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      frame_cnt   <= '0;
      level_cnt   <= '0;
      level       <= 4'd1;
      lives       <= '0;
      score       <= '0;
      count_digit <= '0;
      road_run    <= 1'b0;
      road_clear  <= 1'b1;
`ifdef HISCORE_EN
      hiscore     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      start_q     <= start_btn;
      pause_q     <= pause_btn;
      frame_cnt   <= frame_cnt_nxt;
      level_cnt   <= level_cnt_nxt;
      level       <= level_nxt;
      lives       <= lives_nxt;
      score       <= score_nxt;
      count_digit <= digit_nxt;
      road_run    <= road_run_nxt;
      road_clear  <= road_clear_nxt;
`ifdef HISCORE_EN
      hiscore     <= hiscore_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    level_cnt_nxt = level_cnt;
    level_nxt     = level;
    lives_nxt     = lives;
    score_nxt     = score;
    digit_nxt     = count_digit;
    case (state)
      S_IDLE: begin
        if (start_rise) begin
          lives_nxt     = 2'(LIVES);
          score_nxt     = '0;
          level_nxt     = 4'd1;
          digit_nxt     = 2'd3;
          frame_cnt_nxt = '0;
          level_cnt_nxt = '0;
          state_nxt     = S_COUNTDOWN;
        end
      end
      S_COUNTDOWN: begin
        if (frame_tick) begin
          if (frame_cnt == FW'(COUNT_FRAMES - 1)) begin
            frame_cnt_nxt = '0;
            digit_nxt     = count_digit - 2'd1;
            if (count_digit == 2'd1) state_nxt = S_RUN;
          end else begin
            frame_cnt_nxt = frame_cnt + FW'(1);
          end
        end
      end
      S_RUN: begin
        // crash outranks pause, and both suppress the frame's score/level update
        if (crash) begin
          lives_nxt     = lives - 2'd1;
          frame_cnt_nxt = '0;
          state_nxt     = S_CRASH;
        end else if (pause_rise) begin
          state_nxt = S_PAUSE;
        end else if (frame_tick) begin
          score_nxt = bcd_inc(score);
          if (level_cnt == LW'(LEVEL_FRAMES - 1)) begin
            level_cnt_nxt = '0;
            if (level < 4'(MAX_LEVEL)) level_nxt = level + 4'd1;
          end else begin
            level_cnt_nxt = level_cnt + LW'(1);
          end
        end
      end
      S_PAUSE: begin
        if (pause_rise) state_nxt = S_RUN;
      end
      S_CRASH: begin
        if (frame_tick) begin
          if (frame_cnt == FW'(CRASH_FRAMES - 1)) begin
            frame_cnt_nxt = '0;
            if (lives == 2'd0) begin
              state_nxt = S_OVER;
            end else begin
              digit_nxt = 2'd3;
              state_nxt = S_COUNTDOWN;
            end
          end else begin
            frame_cnt_nxt = frame_cnt + FW'(1);
          end
        end
      end
      S_OVER: begin
        if (start_rise) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // road_clear also pulses for the single cycle that follows a survived crash.
  always_comb begin
    road_run_nxt   = (state_nxt == S_RUN);
    road_clear_nxt = (state_nxt == S_IDLE) || (state_nxt == S_OVER) ||
                     ((state == S_CRASH) && (state_nxt == S_COUNTDOWN));
`ifdef HISCORE_EN
    hiscore_nxt = hiscore;
    if ((state != S_OVER) && (state_nxt == S_OVER) && (score > hiscore))
      hiscore_nxt = score;
`endif
  end

endmodule
